// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states
// and small op-classification helpers.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } md_state_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Decoder <-> mul/div sequencer bundle: op issue, HI/LO moves and status.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs_i;
  logic [XLEN-1:0] rt_i;
  logic            mthi_i;
  logic            mtlo_i;
  logic            mf_req_i;
  logic [XLEN-1:0] hi_o;
  logic [XLEN-1:0] lo_o;
  logic            busy_o;
  logic            done_o;
  logic            stall_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, mf_req_i,
    input  hi_o, lo_o, busy_o, done_o, stall_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, mf_req_i,
    output hi_o, lo_o, busy_o, done_o, stall_o
  );
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step
// on the 2*XLEN accumulator {upper, lower}.
module muldiv_sequencer_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    // Multiply: upper half accumulates the multiplicand, carry shifts back in.
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, b_i} : '0);
    // Divide: remainder picks up the next dividend bit before the trial subtract.
    rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    diff   = rem_sh - {1'b0, b_i};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO registers;
// iterates one bit per cycle and stalls conflicting requests while busy.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  DIV0_LO  = '1;

  function automatic logic [XLEN-1:0] cond_neg_x(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_w(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  md_op_e            op_q, op_d;
  logic              rs_neg_q, rs_neg_d;
  logic              rt_neg_q, rt_neg_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rs_orig_q, rs_orig_d;

  md_op_e            op_in;
  logic              in_signed;
  logic              rs_neg_in;
  logic              rt_neg_in;
  logic [XLEN-1:0]   rs_mag;
  logic [XLEN-1:0]   rt_mag;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;

  muldiv_sequencer_step #(.XLEN(XLEN)) u_step (
    .is_div_i (md_is_div(op_q)),
    .acc_i    (acc_q),
    .b_i      (b_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    op_in     = md_op_e'(bus.op_i);
    in_signed = md_is_signed(op_in);
    rs_neg_in = in_signed & bus.rs_i[XLEN-1];
    rt_neg_in = in_signed & bus.rt_i[XLEN-1];
    rs_mag    = cond_neg_x(rs_neg_in, bus.rs_i);
    rt_mag    = cond_neg_x(rt_neg_in, bus.rt_i);
    // Sign flags are already zero for unsigned ops, so no op check is needed here.
    prod_fix  = cond_neg_w(rs_neg_q ^ rt_neg_q, acc_q);
    quot_fix  = cond_neg_x(rs_neg_q ^ rt_neg_q, acc_q[XLEN-1:0]);
    rem_fix   = cond_neg_x(rs_neg_q, acc_q[2*XLEN-1:XLEN]);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rs_neg_d  = rs_neg_q;
    rt_neg_d  = rt_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    b_d       = b_q;
    rs_orig_d = rs_orig_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          op_d      = op_in;
          rs_neg_d  = rs_neg_in;
          rt_neg_d  = rt_neg_in;
          rs_orig_d = bus.rs_i;
          cnt_d     = '0;
          state_d   = S_CALC;
          if (md_is_div(op_in)) begin
            acc_d = {{XLEN{1'b0}}, rs_mag};
            b_d   = rt_mag;
          end else begin
            acc_d = {{XLEN{1'b0}}, rt_mag};
            b_d   = rs_mag;
          end
        end else begin
          if (bus.mthi_i) hi_d = bus.rs_i;
          if (bus.mtlo_i) lo_d = bus.rs_i;
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (!md_is_div(op_q)) begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end else if (b_q == '0) begin
          // Divide by zero reports the untouched dividend rather than the magnitude.
          hi_d = rs_orig_q;
          lo_d = DIV0_LO;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MULT;
      rs_neg_q <= 1'b0;
      rt_neg_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rs_neg_q <= rs_neg_d;
      rt_neg_q <= rt_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Datapath working registers are always loaded on start before use.
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    b_q       <= b_d;
    rs_orig_q <= rs_orig_d;
  end

  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign bus.busy_o  = (state_q != S_IDLE);
  assign bus.done_o  = done_q;
  assign bus.stall_o = (state_q != S_IDLE) &
                       (bus.start_i | bus.mthi_i | bus.mtlo_i | bus.mf_req_i);

endmodule
